// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - native memory bus responder: word RAM, programmable wait states, out-of-range flagging
// Optional random extra wait states when MEM_RESPONDER_LFSR_WAIT_EN is defined.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [4:0]  wait_total;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [31:0] rdata_r;
    logic        err_r;
    logic [31:0] err_addr_r;
    logic [31:0] fcount_r;

    logic [31:0] ram [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [29:0] word_off;
    logic        in_range;
    logic [AW-1:0] idx;

    assign accept = (state == S_IDLE) && mem_valid;

    `ifdef MEM_RESPONDER_LFSR_WAIT_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; the current value sets this request's extra waits
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign wait_total = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
    `else
    assign wait_total = 5'(WAIT_CYCLES);
    `endif

    // With zero wait states the request goes straight to RESP, so decode the live bus in IDLE
    assign req_addr  = (state == S_IDLE) ? mem_addr  : addr_q;
    assign req_wdata = (state == S_IDLE) ? mem_wdata : wdata_q;
    assign req_wstrb = (state == S_IDLE) ? mem_wstrb : wstrb_q;

    assign word_off = req_addr[31:2] - BASE_ADDR[31:2];
    assign in_range = (req_addr >= BASE_ADDR) && (word_off[29:AW] == '0);
    assign idx      = word_off[AW-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (mem_valid)
                    next_state = (wait_total == 5'd0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (!mem_valid)
                    next_state = S_IDLE;
                else if (cnt == 5'd1)
                    next_state = S_RESP;
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign enter_resp = (next_state == S_RESP);

    always_comb begin
        mem_ready   = (state == S_RESP);
        mem_rdata   = rdata_r;
        err         = err_r;
        err_addr    = err_addr_r;
        fetch_count = fcount_r;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            instr_q    <= 1'b0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
            err_addr_r <= '0;
            fcount_r   <= '0;
        end else begin
            if (accept) begin
                cnt     <= wait_total;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end else if (state == S_WAIT && mem_valid && cnt != 5'd1) begin
                cnt <= cnt - 5'd1;
            end

            err_r <= enter_resp && !in_range;
            if (enter_resp) begin
                rdata_r <= in_range ? ram[idx] : 32'h0;
                if (!in_range)
                    err_addr_r <= req_addr;
            end

            if (state == S_RESP && instr_q)
                fcount_r <= fcount_r + 32'd1;
        end
    end

    // RAM has no reset; gating on reset keeps a request seen during reset from committing
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b])
                    ram[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SPAN = 32'd4096;
    localparam logic [7:0]  SEED = 8'hA5;

    logic        clock = 1'b0;
    logic        reset       [2];
    logic        mem_valid   [2];
    logic        mem_instr   [2];
    logic [31:0] mem_addr    [2];
    logic [31:0] mem_wdata   [2];
    logic [3:0]  mem_wstrb   [2];
    logic        mem_ready   [2];
    logic [31:0] mem_rdata   [2];
    logic        err         [2];
    logic [31:0] err_addr    [2];
    logic [31:0] fetch_count [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_responder #(
            .BASE_ADDR  (BASE),
            .DEPTH_WORDS(1024),
            .WAIT_CYCLES((g == 0) ? 2 : 0),
            .LFSR_SEED  (SEED)
        ) dut (
            .clock      (clock),
            .reset      (reset[g]),
            .mem_valid  (mem_valid[g]),
            .mem_instr  (mem_instr[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_wstrb  (mem_wstrb[g]),
            .mem_ready  (mem_ready[g]),
            .mem_rdata  (mem_rdata[g]),
            .err        (err[g]),
            .err_addr   (err_addr[g]),
            .fetch_count(fetch_count[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [int];
    int          exp_fc  [2];
    logic [31:0] exp_ea  [2];
    `ifdef MEM_RESPONDER_LFSR_WAIT_EN
    logic [7:0]  ref_lfsr [2];

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction
    `endif

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset(input int sel);
        exp_fc[sel] = 0;
        exp_ea[sel] = 32'h0;
        `ifdef MEM_RESPONDER_LFSR_WAIT_EN
        ref_lfsr[sel] = SEED;
        `endif
    endtask

    task automatic txn(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr,
                       output int lat, output logic [31:0] rd, output logic errv);
        lat  = 0;
        rd   = 32'h0;
        errv = 1'b0;
        @(negedge clock);
        mem_valid[sel] = 1'b1;
        mem_instr[sel] = instr;
        mem_addr[sel]  = addr;
        mem_wdata[sel] = wdata;
        mem_wstrb[sel] = wstrb;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (mem_ready[sel]) begin
                lat  = c;
                rd   = mem_rdata[sel];
                errv = err[sel];
                break;
            end
        end
        mem_valid[sel] = 1'b0;
        mem_wstrb[sel] = 4'h0;
        mem_instr[sel] = 1'b0;
    endtask

    // Issue one request and check it against the reference model
    task automatic do_op(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input string tag,
                         output logic [31:0] rd, output int lat);
        int          exp_lat;
        int          key;
        logic        errv;
        logic        inr;
        logic        known;
        logic [31:0] old;
        logic [31:0] nw;
        exp_lat = wait_of(sel) + 1;
        `ifdef MEM_RESPONDER_LFSR_WAIT_EN
        exp_lat += int'(ref_lfsr[sel][1:0]);
        ref_lfsr[sel] = lfsr_next(ref_lfsr[sel]);
        `endif
        inr   = (addr >= BASE) && (addr < BASE + SPAN);
        key   = sel * 4096 + int'((addr - BASE) >> 2);
        known = inr && ref_mem.exists(key);
        old   = known ? ref_mem[key] : 32'h0;

        txn(sel, addr, wdata, wstrb, instr, lat, rd, errv);

        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'h0, errv}, {31'h0, !inr});
        if (!inr) begin
            exp_ea[sel] = addr;
            check({tag, "_rdata_oor"}, rd, 32'h0);
        end else if (wstrb == 4'h0 && known) begin
            check({tag, "_rdata"}, rd, old);
        end
        check({tag, "_err_addr"}, err_addr[sel], exp_ea[sel]);

        if (inr && wstrb != 4'h0) begin
            if (wstrb == 4'hF) begin
                ref_mem[key] = wdata;
            end else if (known) begin
                nw = old;
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) nw[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[key] = nw;
            end
        end
        if (instr) exp_fc[sel]++;

        @(posedge clock);
        #1;
        check({tag, "_fetch_count"}, fetch_count[sel], exp_fc[sel]);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        int          lat;
        int          sel;
        int          r;
        int          ready_seen;

        for (int s = 0; s < 2; s++) begin
            reset[s]     = 1'b1;
            mem_valid[s] = 1'b0;
            mem_instr[s] = 1'b0;
            mem_addr[s]  = 32'h0;
            mem_wdata[s] = 32'h0;
            mem_wstrb[s] = 4'h0;
            model_reset(s);
        end
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst%0d_ready", s), {31'h0, mem_ready[s]}, 32'h0);
            check($sformatf("rst%0d_err", s), {31'h0, err[s]}, 32'h0);
            check($sformatf("rst%0d_rdata", s), mem_rdata[s], 32'h0);
            check($sformatf("rst%0d_err_addr", s), err_addr[s], 32'h0);
            check($sformatf("rst%0d_fetch_count", s), fetch_count[s], 32'h0);
            reset[s] = 1'b0;
        end

        // Known contents for the first 16 words of the WAIT_CYCLES=2 instance
        for (int w = 0; w < 16; w++)
            do_op(0, BASE + 32'(w * 4), $urandom, 4'hF, 1'b0, $sformatf("init%0d", w), rd, lat);

        do_op(0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, "read_lat", rd, lat);
        `ifndef MEM_RESPONDER_LFSR_WAIT_EN
        check("read_lat_is_3", lat, 32'd3);
        `endif
        check("ready_one_cycle", {31'h0, mem_ready[0]}, 32'h0);

        do_op(0, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, "wr_full", rd, lat);
        do_op(0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "rd_full", rd, lat);
        check("rd_deadbeef", rd, 32'hDEAD_BEEF);
        do_op(0, 32'h0001_0004, 32'h0000_AA00, 4'b0010, 1'b0, "wr_lane1", rd, lat);
        do_op(0, 32'h0001_0004, 32'h0, 4'h0, 1'b0, "rd_lane1", rd, lat);
        check("rd_deadaaef", rd, 32'hDEAD_AAEF);

        do_op(0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, "oor_rd", rd, lat);
        check("oor_err_pulse_end", {31'h0, err[0]}, 32'h0);
        check("oor_err_addr_zero", err_addr[0], 32'h0);

        do_op(0, 32'h0001_1000, 32'hFFFF_FFFF, 4'hF, 1'b0, "oor_wr", rd, lat);
        check("oor_wr_err_addr", err_addr[0], 32'h0001_1000);
        for (int w = 0; w < 16; w++)
            do_op(0, BASE + 32'(w * 4), 32'h0, 4'h0, 1'b0, $sformatf("post_oor%0d", w), rd, lat);

        do_op(1, 32'h0001_0000, 32'h0, 4'h0, 1'b1, "fetch0", rd, lat);
        do_op(1, 32'h0001_0004, 32'h0, 4'h0, 1'b1, "fetch1", rd, lat);
        do_op(1, 32'h0001_0008, 32'h0, 4'h0, 1'b1, "fetch2", rd, lat);
        check("three_fetches", fetch_count[1], 32'd3);

        // Reset while a write to 0x10008 sits in WAIT
        @(negedge clock);
        mem_valid[0] = 1'b1;
        mem_instr[0] = 1'b0;
        mem_addr[0]  = 32'h0001_0008;
        mem_wdata[0] = 32'h1234_5678;
        mem_wstrb[0] = 4'hF;
        @(negedge clock);
        ready_seen = mem_ready[0] ? 1 : 0;
        reset[0] = 1'b1;
        model_reset(0);
        #1;
        check("mid_rst_ready", {31'h0, mem_ready[0]}, 32'h0);
        check("mid_rst_err", {31'h0, err[0]}, 32'h0);
        check("mid_rst_rdata", mem_rdata[0], 32'h0);
        check("mid_rst_err_addr", err_addr[0], 32'h0);
        check("mid_rst_fetch_count", fetch_count[0], 32'h0);
        repeat (2) @(negedge clock);
        mem_valid[0] = 1'b0;
        mem_wstrb[0] = 4'h0;
        reset[0]     = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (mem_ready[0]) ready_seen++;
        end
        check("mid_rst_no_ready", ready_seen, 32'd0);
        do_op(0, 32'h0001_0008, 32'h0, 4'h0, 1'b0, "mid_rst_word", rd, lat);

        `ifdef MEM_RESPONDER_LFSR_WAIT_EN
        for (int i = 0; i < 8; i++) begin
            do_op(0, BASE + 32'(i * 4), 32'h0, 4'h0, 1'b0, $sformatf("lfsr_rd%0d", i), rd, lat);
            check($sformatf("lfsr_lat_range%0d", i), {31'h0, (lat >= 3 && lat <= 6)}, 32'h1);
        end
        `endif

        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            if (r < 8)
                addr = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            else if (r == 8)
                addr = $urandom_range(0, BASE - 1);
            else
                addr = BASE + SPAN + ($urandom_range(0, 1023) << 2);
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_op(sel, addr, $urandom, wstrb, 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", i), rd, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
